// File: rtl/sawtooth_pkg.sv
// Shared types and helpers for the PCM sawtooth generator/analyzer pair.
// The increment formula lives here so the generator and any checker agree on the step.
package sawtooth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIME   = 2'd1,
    ACQUIRE = 2'd2,
    LOCKED  = 2'd3
  } analyzer_state_t;

  localparam int unsigned DEFAULT_SAMPLE_RATE = 48000;
  localparam int unsigned DEFAULT_WAVE_RATE   = 480;

  // Per-sample phase step: (2^bit_width - 1) * wave_rate / sample_rate, truncated.
  function automatic int unsigned pcm_increment(input int unsigned bit_width,
                                                input int unsigned wave_rate,
                                                input int unsigned sample_rate);
    longint unsigned full_scale;
    longint unsigned step;
    full_scale = (64'd1 << bit_width) - 64'd1;
    step       = (full_scale * 64'(wave_rate)) / 64'(sample_rate);
    return step[31:0];
  endfunction

endpackage

// File: rtl/pcm_period_counter.sv
// Wrap detector and wrap-to-wrap period counter for a signed PCM ramp.
// A wrap is a positive-to-negative sign change between consecutive samples.
module pcm_period_counter #(
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk_audio,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    prev_msb,
  input  logic                    level_msb,
  input  logic                    clear,
  input  logic                    locked,
  output logic                    wrap,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid
);

  localparam logic [PERIOD_WIDTH-1:0] PCNT_MAX = '1;
  localparam logic [PERIOD_WIDTH-1:0] PCNT_ONE = PERIOD_WIDTH'(1);

  logic [PERIOD_WIDTH-1:0] pcnt;
  logic                    have_wrap;
  logic                    crossing;

  assign crossing = enable && !prev_msb && level_msb;

  always_ff @(posedge clk_audio or negedge rst_n) begin
    if (!rst_n) begin
      wrap         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      pcnt         <= '0;
      have_wrap    <= 1'b0;
    end else begin
      wrap         <= crossing;
      period_valid <= 1'b0;
      if (crossing) begin
        // Only a second wrap seen under a stable lock measures a real period.
        if (have_wrap && locked && !clear) begin
          period       <= pcnt;
          period_valid <= 1'b1;
        end
        pcnt      <= PCNT_ONE;
        have_wrap <= 1'b1;
      end else begin
        if (enable && (pcnt != PCNT_MAX)) begin
          pcnt <= pcnt + PCNT_ONE;
        end
        if (clear) begin
          have_wrap <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sawtooth_analyzer.sv
// Sawtooth stream checker: recovers the modular per-sample step, tracks lock and slip,
// and measures the wrap-to-wrap period through pcm_period_counter.
module sawtooth_analyzer
  import sawtooth_pkg::*;
#(
  parameter int BIT_WIDTH    = 16,
  parameter int LOCK_COUNT   = 8,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk_audio,
  input  logic                    rst_n,
  input  logic [BIT_WIDTH-1:0]    level,
  output logic [BIT_WIDTH-1:0]    increment,
  output logic                    locked,
  output logic                    slip,
  output logic                    wrap,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid
);

  localparam logic [7:0] LOCK_TARGET = 8'(LOCK_COUNT);

  analyzer_state_t      state;
  analyzer_state_t      state_nxt;
  logic [BIT_WIDTH-1:0] prev;
  logic [BIT_WIDTH-1:0] delta;
  logic [BIT_WIDTH-1:0] cand;
  logic [BIT_WIDTH-1:0] cand_nxt;
  logic [BIT_WIDTH-1:0] increment_nxt;
  logic [7:0]           match_cnt;
  logic [7:0]           match_cnt_nxt;
  logic                 locked_nxt;
  logic                 slip_nxt;

  // Modular difference: a full-scale wrap yields the same step as the ramp itself.
  assign delta = level - prev;

  always_ff @(posedge clk_audio or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev      <= '0;
      cand      <= '0;
      match_cnt <= '0;
      increment <= '0;
      locked    <= 1'b0;
      slip      <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev      <= level;
      cand      <= cand_nxt;
      match_cnt <= match_cnt_nxt;
      increment <= increment_nxt;
      locked    <= locked_nxt;
      slip      <= slip_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cand_nxt      = cand;
    match_cnt_nxt = match_cnt;
    increment_nxt = increment;
    locked_nxt    = locked;
    slip_nxt      = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = PRIME;
      end
      PRIME: begin
        cand_nxt      = delta;
        match_cnt_nxt = 8'd1;
        state_nxt     = ACQUIRE;
      end
      ACQUIRE: begin
        if (delta != cand) begin
          cand_nxt      = delta;
          match_cnt_nxt = 8'd1;
        end else if (cand != '0) begin
          // A zero step is DC and must never be reported as a locked ramp.
          if ((match_cnt + 8'd1) == LOCK_TARGET) begin
            state_nxt     = LOCKED;
            locked_nxt    = 1'b1;
            increment_nxt = cand;
          end else begin
            match_cnt_nxt = match_cnt + 8'd1;
          end
        end
      end
      LOCKED: begin
        if (delta != cand) begin
          slip_nxt      = 1'b1;
          locked_nxt    = 1'b0;
          cand_nxt      = delta;
          match_cnt_nxt = 8'd1;
          state_nxt     = ACQUIRE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  pcm_period_counter #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_period (
    .clk_audio   (clk_audio),
    .rst_n       (rst_n),
    .enable      (state != IDLE),
    .prev_msb    (prev[BIT_WIDTH-1]),
    .level_msb   (level[BIT_WIDTH-1]),
    .clear       (slip_nxt),
    .locked      (locked),
    .wrap        (wrap),
    .period      (period),
    .period_valid(period_valid)
  );

endmodule

// File: tb/tb_sawtooth_analyzer.sv
// Self-checking bench for sawtooth_analyzer: ramps, step switch, glitch, DC and reset.
// Expected periods go into exp_q when a crossing sample is driven and are popped on period_valid.
module tb_sawtooth_analyzer;
  import sawtooth_pkg::*;

  localparam int BW = 16;
  localparam int LC = 8;
  localparam int PW = 16;
  localparam int NEVER = 1 << 30;

  logic          clk_audio = 1'b0;
  logic          rst_n;
  logic [BW-1:0] level;
  logic [BW-1:0] increment;
  logic          locked;
  logic          slip;
  logic          wrap;
  logic [PW-1:0] period;
  logic          period_valid;

  // clock / reset
  always #5 clk_audio = ~clk_audio;

  sawtooth_analyzer #(
    .BIT_WIDTH   (BW),
    .LOCK_COUNT  (LC),
    .PERIOD_WIDTH(PW)
  ) dut (
    .clk_audio   (clk_audio),
    .rst_n       (rst_n),
    .level       (level),
    .increment   (increment),
    .locked      (locked),
    .slip        (slip),
    .wrap        (wrap),
    .period      (period),
    .period_valid(period_valid)
  );

  int checks;
  int failures;

  // scoreboard state
  logic [PW-1:0] exp_q[$];
  int            edge_n;
  logic          have_prev;
  logic [BW-1:0] last_lvl;
  logic          prev_locked;
  logic          sb_armed;
  int            sb_last;

  // scenario expectations: lock rises at lock1; optional slip at slip_e, relock at relock_e
  int            lock1;
  int            slip_e;
  int            relock_e;
  logic [BW-1:0] inc_before;
  logic [BW-1:0] inc_after;
  logic [BW-1:0] phase;
  int            pv_count;
  int            wrap_count;
  int            slip_count;

  function automatic logic exp_locked_at(input int e);
    if (e < lock1) return 1'b0;
    if (slip_e != 0 && e >= slip_e && e < relock_e) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [BW-1:0] exp_inc_at(input int e);
    if (slip_e != 0 && e >= relock_e) return inc_after;
    return inc_before;
  endfunction

  // driver: one sample per clock edge, outputs sampled 1 ns after the edge
  task automatic drive_sample(input logic [BW-1:0] lvl);
    int            e;
    logic          crossing;
    logic          exp_lk;
    logic          exp_sl;
    logic [BW-1:0] exp_inc;
    logic [PW-1:0] exp_p;
    e        = edge_n + 1;
    exp_lk   = exp_locked_at(e);
    exp_sl   = (slip_e != 0) && (e == slip_e);
    exp_inc  = exp_inc_at(e);
    crossing = have_prev && !last_lvl[BW-1] && lvl[BW-1];
    @(negedge clk_audio);
    level = lvl;
    if (crossing) begin
      if (sb_armed && prev_locked && !exp_sl) exp_q.push_back(PW'(e - sb_last));
      sb_armed = 1'b1;
      sb_last  = e;
    end else if (exp_sl) begin
      sb_armed = 1'b0;
    end
    @(posedge clk_audio);
    #1;
    edge_n      = e;
    have_prev   = 1'b1;
    last_lvl    = lvl;
    prev_locked = exp_lk;
    if (wrap === 1'b1) wrap_count++;
    if (slip === 1'b1) slip_count++;
    checks++;
    if (wrap !== crossing) begin
      failures++;
      $display("FAIL wrap edge=%0d got=%b exp=%b", e, wrap, crossing);
    end
    checks++;
    if (locked !== exp_lk) begin
      failures++;
      $display("FAIL locked edge=%0d got=%b exp=%b", e, locked, exp_lk);
    end
    checks++;
    if (slip !== exp_sl) begin
      failures++;
      $display("FAIL slip edge=%0d got=%b exp=%b", e, slip, exp_sl);
    end
    if (exp_lk) begin
      checks++;
      if (increment !== exp_inc) begin
        failures++;
        $display("FAIL increment edge=%0d got=%0d exp=%0d", e, increment, exp_inc);
      end
    end
    if (period_valid !== 1'b0) begin
      pv_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL period_valid edge=%0d got=%b exp=0 (no period expected)", e, period_valid);
      end else begin
        exp_p = exp_q.pop_front();
        if (period !== exp_p) begin
          failures++;
          $display("FAIL period edge=%0d got=%0d exp=%0d", e, period, exp_p);
        end
      end
    end
  endtask

  task automatic run_ramp(input int n, input logic [BW-1:0] inc, input int glitch_e);
    for (int i = 0; i < n; i++) begin
      phase = phase + inc;
      if (edge_n + 1 == glitch_e) drive_sample(phase + BW'(1));
      else drive_sample(phase);
    end
  endtask

  task automatic apply_reset(input int hold_cycles);
    @(negedge clk_audio);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (increment !== '0) begin failures++; $display("FAIL reset_increment got=%0d exp=0", increment); end
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++;
    if (slip !== 1'b0) begin failures++; $display("FAIL reset_slip got=%b exp=0", slip); end
    checks++;
    if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    checks++;
    if (period !== '0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period); end
    checks++;
    if (period_valid !== 1'b0) begin failures++; $display("FAIL reset_period_valid got=%b exp=0", period_valid); end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_periods got=%0d exp=0", exp_q.size());
    end
    exp_q.delete();
    repeat (hold_cycles) @(posedge clk_audio);
    #2;
    rst_n       = 1'b1;
    edge_n      = 0;
    have_prev   = 1'b0;
    last_lvl    = '0;
    prev_locked = 1'b0;
    sb_armed    = 1'b0;
    sb_last     = 0;
    lock1       = NEVER;
    slip_e      = 0;
    relock_e    = 0;
  endtask

  task automatic lock_sequence();
    lock1      = LC + 1;
    slip_e     = 0;
    inc_before = BW'(pcm_increment(BW, DEFAULT_WAVE_RATE, DEFAULT_SAMPLE_RATE));
    inc_after  = inc_before;
    phase      = BW'(0) - inc_before;
    pv_count   = 0;
    slip_count = 0;
    run_ramp(260, inc_before, 0);
    // crossings at edges 52, 152, 252: the first only arms the counter
    checks++;
    if (pv_count != 2) begin
      failures++;
      $display("FAIL lock_seq_period_count got=%0d exp=2", pv_count);
    end
    checks++;
    if (slip_count != 0) begin
      failures++;
      $display("FAIL lock_seq_slips got=%0d exp=0", slip_count);
    end
  endtask

  task automatic test_reset();
    apply_reset(2);
  endtask

  task automatic test_lock_from_reset();
    lock_sequence();
  endtask

  task automatic test_long_ramp();
    wrap_count = 0;
    slip_count = 0;
    run_ramp(2200, inc_before, 0);
    checks++;
    if (wrap_count < 21) begin
      failures++;
      $display("FAIL long_ramp_wraps got=%0d exp>=21", wrap_count);
    end
    checks++;
    if (slip_count != 0) begin
      failures++;
      $display("FAIL long_ramp_slips got=%0d exp=0", slip_count);
    end
  endtask

  task automatic test_increment_switch();
    slip_e     = edge_n + 1;
    relock_e   = slip_e + LC - 1;
    inc_after  = 16'd1311;
    pv_count   = 0;
    slip_count = 0;
    run_ramp(300, inc_after, 0);
    checks++;
    if (slip_count != 1) begin
      failures++;
      $display("FAIL switch_slips got=%0d exp=1", slip_count);
    end
    checks++;
    if (pv_count < 4) begin
      failures++;
      $display("FAIL switch_period_count got=%0d exp>=4", pv_count);
    end
  endtask

  task automatic test_mid_run_reset();
    run_ramp(30, inc_after, 0);
    apply_reset(3);
    lock_sequence();
  endtask

  task automatic test_dc_level();
    apply_reset(2);
    pv_count   = 0;
    wrap_count = 0;
    for (int i = 0; i < 200; i++) drive_sample(16'h1234);
    checks++;
    if (pv_count != 0 || wrap_count != 0) begin
      failures++;
      $display("FAIL dc_activity got=%0d/%0d exp=0/0", pv_count, wrap_count);
    end
  endtask

  task automatic test_glitch();
    int g;
    apply_reset(2);
    g          = 50 + int'($urandom_range(4, 12));
    lock1      = LC + 1;
    slip_e     = g;
    relock_e   = g + LC + 1;
    inc_before = 16'd655;
    inc_after  = 16'd655;
    phase      = BW'(0) - inc_before;
    pv_count   = 0;
    slip_count = 0;
    run_ramp(360, inc_before, g);
    // wrap at 52 is cleared by the slip, 152 re-arms, 252 and 352 publish
    checks++;
    if (slip_count != 1) begin
      failures++;
      $display("FAIL glitch_slips got=%0d exp=1", slip_count);
    end
    checks++;
    if (pv_count != 2) begin
      failures++;
      $display("FAIL glitch_period_count got=%0d exp=2", pv_count);
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    level      = '0;
    checks     = 0;
    failures   = 0;
    pv_count   = 0;
    wrap_count = 0;
    slip_count = 0;
    test_reset();
    test_lock_from_reset();
    test_long_ramp();
    test_increment_switch();
    test_mid_run_reset();
    test_dc_level();
    test_glitch();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_pending_periods got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
